// File: rtl/deconv2x2_upsampler.sv
// Purpose : 2x2 transposed convolution, scatters a 3x3 input map into a 4x4 buffer and streams it out.
// Latency : accepts one pixel per cycle; the 4x4 result streams out from the cycle after the 9th accept.
// Backpress: in_ready low for the whole drain; out_ready low holds out_data and the read index.
//
// Ports:
//   CLK, RSTn              clock, synchronous active-low reset
//   in_valid/in_data/in_ready     8-bit unsigned input pixel stream (row-major, 9 per frame)
//   out_valid/out_data/out_ready  14-bit unsigned output stream (row-major, 16 per frame)
//   frame_sum              sum of the 16 values drained in the last completed frame
//   frame_done             high during the final output handshake of a frame
// Build option: define DECONV_SAT8_EN to clamp out_data (and frame_sum terms) to 255.
module deconv2x2_upsampler #(
    parameter logic [3:0] CORE2X2_0 = 4'b0010,  // tap for out[r+1][c+1]
    parameter logic [3:0] CORE2X2_1 = 4'b0010,  // tap for out[r+1][c]
    parameter logic [3:0] CORE2X2_2 = 4'b0010,  // tap for out[r][c+1]
    parameter logic [3:0] CORE2X2_3 = 4'b0010   // tap for out[r][c]
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        out_valid,
    output logic [13:0] out_data,
    input  logic        out_ready,
    output logic [17:0] frame_sum,
    output logic        frame_done
);

    localparam logic ST_ACC   = 1'b0;
    localparam logic ST_DRAIN = 1'b1;

    logic        state;
    logic [13:0] cell_q [16];
    // The input index k is kept as (row, col) so k/3 and k%3 never need computing.
    logic [1:0]  in_row;
    logic [1:0]  in_col;
    logic [3:0]  out_idx;
    logic [17:0] acc_q;

    logic        accept;
    logic        drain_hs;
    logic        last_out;
    logic [3:0]  base;
    logic [11:0] p0, p1, p2, p3;
    logic [11:0] add [16];
    logic [13:0] cell_rd;
    logic [13:0] out_val;

    assign in_ready   = (state == ST_ACC);
    assign out_valid  = (state == ST_DRAIN);
    assign accept     = in_ready && in_valid;
    assign drain_hs   = out_valid && out_ready;
    assign last_out   = (out_idx == 4'd15);
    assign frame_done = drain_hs && last_out;

    assign base = {in_row, 2'b00} + {2'b00, in_col};
    assign p0   = 12'(in_data) * 12'(CORE2X2_0);
    assign p1   = 12'(in_data) * 12'(CORE2X2_1);
    assign p2   = 12'(in_data) * 12'(CORE2X2_2);
    assign p3   = 12'(in_data) * 12'(CORE2X2_3);

    // The four target cells of one pixel are always distinct, so each cell
    // receives at most one product per cycle.
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            add[i] = '0;
        end
        if (accept) begin
            add[base]         = p3;
            add[base + 4'd1]  = p2;
            add[base + 4'd4]  = p1;
            add[base + 4'd5]  = p0;
        end
    end

    assign cell_rd = cell_q[out_idx];

`ifdef DECONV_SAT8_EN
    assign out_val = (cell_rd > 14'd255) ? 14'd255 : {6'b0, cell_rd[7:0]};
`else
    assign out_val = cell_rd;
`endif

    assign out_data = out_valid ? out_val : 14'd0;

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state     <= ST_ACC;
            in_row    <= 2'd0;
            in_col    <= 2'd0;
            out_idx   <= 4'd0;
            acc_q     <= 18'd0;
            frame_sum <= 18'd0;
            for (int i = 0; i < 16; i++) begin
                cell_q[i] <= 14'd0;
            end
        end else begin
            if (accept) begin
                for (int i = 0; i < 16; i++) begin
                    cell_q[i] <= cell_q[i] + {2'b00, add[i]};
                end
                if (in_col == 2'd2) begin
                    in_col <= 2'd0;
                    if (in_row == 2'd2) begin
                        in_row <= 2'd0;
                        state  <= ST_DRAIN;
                    end else begin
                        in_row <= in_row + 2'd1;
                    end
                end else begin
                    in_col <= in_col + 2'd1;
                end
            end
            if (drain_hs) begin
                if (last_out) begin
                    frame_sum <= acc_q + {4'b0, out_data};
                    acc_q     <= 18'd0;
                    out_idx   <= 4'd0;
                    state     <= ST_ACC;
                    for (int i = 0; i < 16; i++) begin
                        cell_q[i] <= 14'd0;
                    end
                end else begin
                    acc_q   <= acc_q + {4'b0, out_data};
                    out_idx <= out_idx + 4'd1;
                end
            end
        end
    end

endmodule
